// File: rtl/blackjack_pkg.sv
// Shared deck constants, rank constants and the dealer FSM state type.
package blackjack_pkg;

    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;
    localparam int SUITS     = 4;

    localparam logic [3:0] RANK_ACE  = 4'd1;
    localparam logic [3:0] RANK_JACK = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        PROBE,
        DEAL
    } deal_state_t;

endpackage

// File: rtl/card_decode.sv
// Combinational deck index (0..51) to rank, suit, blackjack points and ace flag.
module card_decode
    import blackjack_pkg::*;
(
    input  logic [5:0] idx,
    output logic [3:0] rank,
    output logic [1:0] suit,
    output logic [3:0] points,
    output logic       is_ace
);

    localparam logic [5:0] SUIT1_BASE = 6'(RANKS);
    localparam logic [5:0] SUIT2_BASE = 6'(2 * RANKS);
    localparam logic [5:0] SUIT3_BASE = 6'(3 * RANKS);

    logic [3:0] rem;

    // Suit is idx/13 and rank offset is idx%13, done as a compare chain.
    always_comb begin
        suit = 2'd0;
        rem  = idx[3:0];
        if (idx >= SUIT3_BASE) begin
            suit = 2'd3;
            rem  = 4'(idx - SUIT3_BASE);
        end else if (idx >= SUIT2_BASE) begin
            suit = 2'd2;
            rem  = 4'(idx - SUIT2_BASE);
        end else if (idx >= SUIT1_BASE) begin
            suit = 2'd1;
            rem  = 4'(idx - SUIT1_BASE);
        end
        rank   = rem + 4'd1;
        points = (rank >= RANK_JACK) ? 4'd10 : rank;
        is_ace = (rank == RANK_ACE);
    end

endmodule

// File: rtl/card_dealer.sv
// Deals unique cards from a 52-card deck using a snapshot of the free-running count.
// Define CARD_DEALER_LFSR_EN to whiten the snapshot with a 16-bit Galois LFSR (WIDTH <= 16).
module card_dealer
    import blackjack_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int DECK_SIZE = 52
) (
    input  logic             clk_50M,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] i_Count,
    input  logic             i_Draw,
    input  logic             i_NewDeck,
    output logic             o_Busy,
    output logic             o_CardValid,
    output logic [3:0]       o_Rank,
    output logic [1:0]       o_Suit,
    output logic [3:0]       o_Points,
    output logic             o_IsAce,
    output logic [5:0]       o_CardsLeft,
    output logic             o_Empty,
    output logic             o_DrawErr
);

    localparam logic [WIDTH-1:0] DECK_W   = WIDTH'(DECK_SIZE);
    localparam logic [5:0]       LAST_IDX = 6'(DECK_SIZE - 1);
    localparam logic [5:0]       FULL     = 6'(DECK_SIZE);

    deal_state_t            state_q, state_d;
    logic [WIDTH-1:0]       idx_q;
    logic [DECK_SIZE-1:0]   used_q;
    logic [5:0]             idx6;
    logic [WIDTH-1:0]       snap;
    logic [3:0]             dec_rank, dec_points;
    logic [1:0]             dec_suit;
    logic                   dec_ace;

    assign idx6    = idx_q[5:0];
    assign o_Empty = (o_CardsLeft == 6'd0);

`ifdef CARD_DEALER_LFSR_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign snap = i_Count ^ lfsr_q[WIDTH-1:0];
`else
    assign snap = i_Count;
`endif

    card_decode u_decode (
        .idx    (idx6),
        .rank   (dec_rank),
        .suit   (dec_suit),
        .points (dec_points),
        .is_ace (dec_ace)
    );

    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A new deck overrides everything, including a draw arriving the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_Draw && !o_Empty) state_d = REDUCE;
            REDUCE:  if (idx_q < DECK_W) state_d = PROBE;
            PROBE:   if (!used_q[idx6]) state_d = DEAL;
            DEAL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_NewDeck) state_d = IDLE;
    end

    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            idx_q       <= '0;
            used_q      <= '0;
            o_CardsLeft <= FULL;
            o_Busy      <= 1'b0;
            o_CardValid <= 1'b0;
            o_DrawErr   <= 1'b0;
            o_Rank      <= 4'd0;
            o_Suit      <= 2'd0;
            o_Points    <= 4'd0;
            o_IsAce     <= 1'b0;
        end else begin
            o_CardValid <= 1'b0;
            o_DrawErr   <= 1'b0;
            if (i_NewDeck) begin
                used_q      <= '0;
                o_CardsLeft <= FULL;
                o_Busy      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_Draw) begin
                            if (o_Empty) begin
                                o_DrawErr <= 1'b1;
                            end else begin
                                idx_q  <= snap;
                                o_Busy <= 1'b1;
                            end
                        end
                    end
                    REDUCE: begin
                        if (idx_q >= DECK_W) idx_q <= idx_q - DECK_W;
                    end
                    PROBE: begin
                        // Linear probe with wrap; a free slot exists since the deck was not empty at accept.
                        if (used_q[idx6]) begin
                            idx_q <= (idx6 == LAST_IDX) ? '0 : idx_q + 1'b1;
                        end
                    end
                    DEAL: begin
                        used_q[idx6] <= 1'b1;
                        o_CardsLeft  <= o_CardsLeft - 6'd1;
                        o_Rank       <= dec_rank;
                        o_Suit       <= dec_suit;
                        o_Points     <= dec_points;
                        o_IsAce      <= dec_ace;
                        o_CardValid  <= 1'b1;
                        o_Busy       <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
